// File: rtl/cpu_mem_map.sv
// Z80-side memory controller: decodes the T80 bus onto ROM/RAM/VRAM, loads the ROM
// from the HPS download channel, sequences CPU reset and inserts read wait states.
module cpu_mem_map #(
  parameter int ROM_AW     = 12,
  parameter int RAM_AW     = 12,
  parameter int VRAM_AW    = 14,
  parameter int RST_CYCLES = 256,
  parameter int RD_WAIT    = 0
) (
  input  logic               clk_sys_i,
  input  logic               reset_i,
  input  logic               ioctl_download_i,
  input  logic               ioctl_wr_i,
  input  logic [26:0]        ioctl_addr_i,
  input  logic [7:0]         ioctl_dout_i,
  input  logic [15:0]        cpu_addr_i,
  input  logic [7:0]         cpu_dout_i,
  input  logic               cpu_mreq_n_i,
  input  logic               cpu_rd_n_i,
  input  logic               cpu_wr_n_i,
  output logic [7:0]         cpu_din_o,
  output logic               cpu_wait_n_o,
  output logic               cpu_reset_o,
  output logic [ROM_AW-1:0]  rom_addr_o,
  output logic               rom_wr_o,
  output logic [7:0]         rom_data_o,
  input  logic [7:0]         rom_q_i,
  output logic [RAM_AW-1:0]  ram_addr_o,
  output logic               ram_wren_o,
  output logic [7:0]         ram_data_o,
  input  logic [7:0]         ram_q_i,
  output logic               vram_wr_o,
  output logic [VRAM_AW-1:0] vram_addr_o,
  output logic [7:0]         vram_data_o,
  output logic               busy_o
);

  localparam logic [15:0] CNT_LAST  = 16'(RST_CYCLES - 1);
  localparam logic [2:0]  RD_WAIT_W = 3'(RD_WAIT);

  typedef enum logic [1:0] {
    RST_HOLD,
    RUN,
    LOAD
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;

  logic               wrPrev_q, wrPrev_d;
  logic               rdPrev_q, rdPrev_d;
  logic               a15_q, a15_d;
  logic               ramWren_q, ramWren_d;
  logic               vramWr_q, vramWr_d;
  logic [7:0]         wrData_q, wrData_d;
  logic [VRAM_AW-1:0] vramAddr_q, vramAddr_d;
  logic [2:0]         waitCnt_q, waitCnt_d;
  logic               romWr_q, romWr_d;
  logic [ROM_AW-1:0]  romLdAddr_q, romLdAddr_d;
  logic [7:0]         romData_q, romData_d;

  logic wrCycle;
  logic rdCycle;
  logic runActive;
  logic wrStart;
  logic rdStart;
  logic romHit;
  logic unusedAddrBits;

  // A download request in the current cycle already counts as an abort, so it beats a
  // CPU strobe or read start sampled on the same edge.
  assign runActive = (state_q == RUN) && !ioctl_download_i;
  assign wrCycle   = !cpu_mreq_n_i && !cpu_wr_n_i;
  assign rdCycle   = !cpu_mreq_n_i && !cpu_rd_n_i;
  assign wrStart   = wrCycle && !wrPrev_q && runActive;
  assign rdStart   = rdCycle && !rdPrev_q && runActive;
  assign romHit    = (ioctl_addr_i >> ROM_AW) == 27'd0;

  assign unusedAddrBits = ^cpu_addr_i;

  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      state_q <= RST_HOLD;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RST_HOLD: begin
        if (cnt_q == CNT_LAST) begin
          state_d = RUN;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      LOAD: begin
        if (!ioctl_download_i) begin
          state_d = RST_HOLD;
          cnt_d   = 16'd0;
        end
      end
      default: begin
        state_d = RST_HOLD;
        cnt_d   = 16'd0;
      end
    endcase
    if (ioctl_download_i) begin
      state_d = LOAD;
      cnt_d   = 16'd0;
    end
  end

  always_comb begin
    cpu_reset_o = 1'b1;
    busy_o      = 1'b0;
    rom_addr_o  = cpu_addr_i[ROM_AW-1:0];
    rom_wr_o    = 1'b0;
    case (state_q)
      RUN: begin
        cpu_reset_o = 1'b0;
      end
      LOAD: begin
        busy_o     = 1'b1;
        rom_addr_o = romLdAddr_q;
        rom_wr_o   = romWr_q;
      end
      default: begin
        cpu_reset_o = 1'b1;
      end
    endcase
    cpu_wait_n_o = reset_i || !runActive || (waitCnt_q == 3'd0);
  end

  // Bus-cycle tracking, strobe generation, wait counting and download capture.
  always_comb begin
    wrPrev_d    = wrCycle;
    rdPrev_d    = rdCycle;
    a15_d       = cpu_addr_i[15];
    ramWren_d   = 1'b0;
    vramWr_d    = 1'b0;
    wrData_d    = wrData_q;
    vramAddr_d  = vramAddr_q;
    romWr_d     = 1'b0;
    romLdAddr_d = romLdAddr_q;
    romData_d   = romData_q;
    waitCnt_d   = (waitCnt_q != 3'd0) ? (waitCnt_q - 3'd1) : 3'd0;

    if (wrStart) begin
      ramWren_d = cpu_addr_i[15];
      vramWr_d  = !cpu_addr_i[15];
      wrData_d  = cpu_dout_i;
      if (!cpu_addr_i[15]) begin
        vramAddr_d = cpu_addr_i[VRAM_AW-1:0];
      end
    end

    if (rdStart) begin
      waitCnt_d = RD_WAIT_W;
    end
    if (!runActive) begin
      waitCnt_d = 3'd0;
    end

    if (ioctl_wr_i && ioctl_download_i && romHit) begin
      romWr_d     = 1'b1;
      romLdAddr_d = ioctl_addr_i[ROM_AW-1:0];
      romData_d   = ioctl_dout_i;
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      wrPrev_q    <= 1'b0;
      rdPrev_q    <= 1'b0;
      a15_q       <= 1'b0;
      ramWren_q   <= 1'b0;
      vramWr_q    <= 1'b0;
      wrData_q    <= 8'd0;
      vramAddr_q  <= '0;
      waitCnt_q   <= 3'd0;
      romWr_q     <= 1'b0;
      romLdAddr_q <= '0;
      romData_q   <= 8'd0;
    end else begin
      wrPrev_q    <= wrPrev_d;
      rdPrev_q    <= rdPrev_d;
      a15_q       <= a15_d;
      ramWren_q   <= ramWren_d;
      vramWr_q    <= vramWr_d;
      wrData_q    <= wrData_d;
      vramAddr_q  <= vramAddr_d;
      waitCnt_q   <= waitCnt_d;
      romWr_q     <= romWr_d;
      romLdAddr_q <= romLdAddr_d;
      romData_q   <= romData_d;
    end
  end

  // The read mux uses the address from the previous cycle to line up with memory latency.
  assign cpu_din_o   = a15_q ? ram_q_i : rom_q_i;
  assign rom_data_o  = romData_q;
  assign ram_addr_o  = cpu_addr_i[RAM_AW-1:0];
  assign ram_wren_o  = ramWren_q;
  assign ram_data_o  = wrData_q;
  assign vram_wr_o   = vramWr_q;
  assign vram_addr_o = vramAddr_q;
  assign vram_data_o = wrData_q;

endmodule

// File: tb/tb_cpu_mem_map.sv
// Self-checking bench for cpu_mem_map: reset sequencing, ROM download, CPU write
// decode, read wait states / data mux, and download-abort corner cases.
module tb_cpu_mem_map;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctlDownload;
  logic        ioctlWr;
  logic [26:0] ioctlAddr;
  logic [7:0]  ioctlDout;
  logic [15:0] cpuAddr;
  logic [7:0]  cpuDout;
  logic        mreqN;
  logic        rdN;
  logic        wrN;
  logic [7:0]  cpuDin;
  logic        cpuWaitN;
  logic        cpuReset;
  logic [11:0] romAddr;
  logic        romWr;
  logic [7:0]  romData;
  logic [7:0]  romQ;
  logic [11:0] ramAddr;
  logic        ramWren;
  logic [7:0]  ramData;
  logic [7:0]  ramQ;
  logic        vramWr;
  logic [13:0] vramAddr;
  logic [7:0]  vramData;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          hold;
    int          expRam;
    int          expVram;
    logic [11:0] expRamAddr;
    logic [13:0] expVramAddr;
  } wrVec_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  ramQ;
    logic [7:0]  romQ;
    logic [7:0]  expDin;
  } rdVec_t;

  wrVec_t wrVecs[5];
  rdVec_t rdVecs[4];

  always #5 clk = ~clk;

  cpu_mem_map #(
    .ROM_AW(12), .RAM_AW(12), .VRAM_AW(14), .RST_CYCLES(256), .RD_WAIT(2)
  ) dut (
    .clk_sys_i(clk), .reset_i(reset),
    .ioctl_download_i(ioctlDownload), .ioctl_wr_i(ioctlWr),
    .ioctl_addr_i(ioctlAddr), .ioctl_dout_i(ioctlDout),
    .cpu_addr_i(cpuAddr), .cpu_dout_i(cpuDout),
    .cpu_mreq_n_i(mreqN), .cpu_rd_n_i(rdN), .cpu_wr_n_i(wrN),
    .cpu_din_o(cpuDin), .cpu_wait_n_o(cpuWaitN), .cpu_reset_o(cpuReset),
    .rom_addr_o(romAddr), .rom_wr_o(romWr), .rom_data_o(romData), .rom_q_i(romQ),
    .ram_addr_o(ramAddr), .ram_wren_o(ramWren), .ram_data_o(ramData), .ram_q_i(ramQ),
    .vram_wr_o(vramWr), .vram_addr_o(vramAddr), .vram_data_o(vramData),
    .busy_o(busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data,
                               input logic m, input logic r, input logic w);
    cpuAddr = addr;
    cpuDout = data;
    mreqN   = m;
    rdN     = r;
    wrN     = w;
  endtask

  task automatic idleBus();
    mreqN = 1'b1;
    rdN   = 1'b1;
    wrN   = 1'b1;
  endtask

  task automatic measureResetHold(output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      if (cpuReset !== 1'b1) break;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic ioctlWrite(input logic [26:0] addr, input logic [7:0] data, input logic expWr);
    logic [11:0] lowAddr;
    lowAddr   = addr[11:0];
    ioctlAddr = addr;
    ioctlDout = data;
    ioctlWr   = 1'b1;
    @(negedge clk);
    ioctlWr = 1'b0;
    checkOutput("rom_wr", romWr, expWr);
    if (expWr) begin
      checkOutput("rom_addr_load", romAddr, lowAddr);
      checkOutput("rom_data", romData, data);
    end
    checkOutput("busy_load", busy, 1);
    checkOutput("cpu_reset_load", cpuReset, 1);
    @(negedge clk);
    checkOutput("rom_wr_single", romWr, 0);
  endtask

  task automatic runWriteVec(input wrVec_t v);
    int ramPulses;
    int vramPulses;
    ramPulses  = 0;
    vramPulses = 0;
    applyStimulus(v.addr, v.data, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k <= v.hold; k++) begin
      @(negedge clk);
      if (ramWren === 1'b1) begin
        ramPulses++;
        checkOutput("ram_addr", ramAddr, v.expRamAddr);
        checkOutput("ram_data", ramData, v.data);
      end
      if (vramWr === 1'b1) begin
        vramPulses++;
        checkOutput("vram_addr", vramAddr, v.expVramAddr);
        checkOutput("vram_data", vramData, v.data);
      end
      if (k == v.hold - 1) idleBus();
    end
    @(negedge clk);
    checkOutput("ram_wren_pulses", ramPulses, v.expRam);
    checkOutput("vram_wr_pulses", vramPulses, v.expVram);
  endtask

  task automatic runReadVec(input rdVec_t v);
    int waitLow;
    int firstLow;
    logic [11:0] lowAddr;
    waitLow  = 0;
    firstLow = -1;
    lowAddr  = v.addr[11:0];
    ramQ     = v.ramQ;
    romQ     = v.romQ;
    applyStimulus(v.addr, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (cpuWaitN === 1'b0) begin
        if (firstLow < 0) firstLow = k;
        waitLow++;
      end
      if (k == 0) checkOutput("rom_addr_run", romAddr, lowAddr);
    end
    checkOutput("cpu_din", cpuDin, v.expDin);
    checkOutput("wait_low_cycles", waitLow, 2);
    checkOutput("wait_first_cycle", firstLow, 0);
    idleBus();
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int holdCycles;

    wrVecs[0] = '{16'h8010, 8'h42, 3, 1, 0, 12'h010, 14'h0010};
    wrVecs[1] = '{16'h1234, 8'h7F, 1, 0, 1, 12'h234, 14'h1234};
    wrVecs[2] = '{16'hFFFF, 8'hA5, 2, 1, 0, 12'hFFF, 14'h3FFF};
    wrVecs[3] = '{16'h0000, 8'h01, 4, 0, 1, 12'h000, 14'h0000};
    wrVecs[4] = '{16'h7FFF, 8'hC3, 2, 0, 1, 12'hFFF, 14'h3FFF};

    rdVecs[0] = '{16'h8000, 8'h99, 8'h11, 8'h99};
    rdVecs[1] = '{16'h0005, 8'h99, 8'h11, 8'h11};
    rdVecs[2] = '{16'hFFFF, 8'h3C, 8'hC3, 8'h3C};
    rdVecs[3] = '{16'h7FFF, 8'h3C, 8'hC3, 8'hC3};

    reset         = 1'b1;
    ioctlDownload = 1'b0;
    ioctlWr       = 1'b0;
    ioctlAddr     = '0;
    ioctlDout     = '0;
    ramQ          = '0;
    romQ          = '0;
    applyStimulus(16'h0000, 8'h00, 1'b1, 1'b1, 1'b1);

    // T1: reset values and reset hold length
    repeat (3) @(negedge clk);
    checkOutput("reset_cpu_reset", cpuReset, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_wait_n", cpuWaitN, 1);
    checkOutput("reset_ram_wren", ramWren, 0);
    checkOutput("reset_vram_wr", vramWr, 0);
    checkOutput("reset_rom_wr", romWr, 0);
    reset = 1'b0;
    measureResetHold(holdCycles);
    checkOutput("t1_reset_hold", holdCycles, 256);
    checkOutput("t1_busy", busy, 0);

    // T2: ROM download with one out-of-range byte
    ioctlDownload = 1'b1;
    @(negedge clk);
    checkOutput("t2_busy", busy, 1);
    checkOutput("t2_cpu_reset", cpuReset, 1);
    ioctlWrite(27'h000, 8'h3E, 1'b1);
    ioctlWrite(27'h001, 8'hAA, 1'b1);
    ioctlWrite(27'h1000, 8'h55, 1'b0);
    ioctlDownload = 1'b0;
    @(negedge clk);
    checkOutput("t2_busy_end", busy, 0);
    measureResetHold(holdCycles);
    checkOutput("t2_reset_hold", holdCycles, 256);

    // T3/T4: CPU write decode
    for (int i = 0; i < 5; i++) runWriteVec(wrVecs[i]);

    // T5: reads with wait states and data mux
    for (int i = 0; i < 4; i++) runReadVec(rdVecs[i]);

    // Download aborting a wait burst
    applyStimulus(16'h8000, 8'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("abort_wait_started", cpuWaitN, 0);
    ioctlDownload = 1'b1;
    #1;
    checkOutput("abort_wait_immediate", cpuWaitN, 1);
    @(negedge clk);
    checkOutput("abort_wait_after", cpuWaitN, 1);
    checkOutput("abort_busy", busy, 1);
    @(negedge clk);
    checkOutput("abort_wait_stays", cpuWaitN, 1);
    idleBus();
    ioctlDownload = 1'b0;
    @(negedge clk);
    measureResetHold(holdCycles);
    checkOutput("abort_reset_hold", holdCycles, 256);

    // T6: download start coincides with a CPU write
    applyStimulus(16'h8000, 8'h55, 1'b0, 1'b1, 1'b0);
    ioctlDownload = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("t6_no_ram_wren", ramWren, 0);
      checkOutput("t6_no_vram_wr", vramWr, 0);
      if (k == 0) begin
        checkOutput("t6_cpu_reset", cpuReset, 1);
        checkOutput("t6_busy", busy, 1);
      end
    end
    idleBus();
    ioctlDownload = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
